// File: rtl/reg_dump_engine_if.sv
// Register-dump bus: start/abort control, register-file debug read port
// and the text-buffer write port.
interface reg_dump_engine_if #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 13
);
  localparam int REG_AW = $clog2(NUM_REGS);

  logic                 start;
  logic                 abort;
  logic [REG_AW-1:0]    first_reg;
  logic [REG_AW-1:0]    last_reg;
  logic [REG_AW-1:0]    reg_addr;
  logic [WORD_SIZE-1:0] reg_data;
  logic                 ascii_write_en;
  logic [ADDR_W-1:0]    ascii_write_address;
  logic [31:0]          ascii_input;
  logic                 busy;
  logic                 done;

  modport master (
    input  start,
    input  abort,
    input  first_reg,
    input  last_reg,
    input  reg_data,
    output reg_addr,
    output ascii_write_en,
    output ascii_write_address,
    output ascii_input,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output first_reg,
    output last_reg,
    output reg_data,
    input  reg_addr,
    input  ascii_write_en,
    input  ascii_write_address,
    input  ascii_input,
    input  busy,
    input  done
  );
endinterface

// File: rtl/reg_dump_engine.sv
// Walks a register range and writes each word as hex text,
// one row per register, into a character buffer.
module reg_dump_engine #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_REGS   = 32,
  parameter int ROW_STRIDE = 80,
  parameter int COL_OFFSET = 0,
  parameter int ADDR_W     = 13
) (
  input logic               clk,
  input logic               rst,
  reg_dump_engine_if.master bus
);
  localparam int DIGITS = WORD_SIZE / 4;
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int DW     = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    EMIT,
    NEXT,
    FIN
  } state_e;

  state_e               state_q, state_d;
  logic [REG_AW-1:0]    cur_q, cur_d;
  logic [REG_AW-1:0]    last_q, last_d;
  logic [REG_AW-1:0]    raddr_q, raddr_d;
  logic [DW-1:0]        d_q, d_d;
  logic [WORD_SIZE-1:0] sh_q, sh_d;
  logic [ADDR_W-1:0]    wa_q, wa_d;
  logic [31:0]          wd_q, wd_d;

  logic [ADDR_W-1:0]    live_addr;
  logic [31:0]          live_data;
  logic [3:0]           nib;
  logic [7:0]           chr;
  logic                 emit;
  logic                 last_dig;
  logic                 at_top;

  assign nib = sh_q[WORD_SIZE-1 -: 4];
  assign chr = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                             : (8'h37 + {4'h0, nib});
  assign live_data = {chr, 24'hFF_FFFF};

  // Modular arithmetic in ADDR_W bits gives the buffer wrap for free
  assign live_addr = ADDR_W'(cur_q) * ADDR_W'(ROW_STRIDE)
                   + ADDR_W'(COL_OFFSET)
                   + ADDR_W'(d_q);

  assign last_dig = (d_q == DW'(DIGITS - 1));
  assign at_top   = (cur_q == REG_AW'(NUM_REGS - 1));
  assign emit     = (state_q == EMIT) && !bus.abort;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    raddr_d = raddr_q;
    d_d     = d_q;
    sh_d    = sh_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          cur_d   = bus.first_reg;
          last_d  = bus.last_reg;
          state_d = READ;
        end
      end
      READ: begin
        raddr_d = cur_q;
        state_d = LATCH;
      end
      LATCH: begin
        sh_d    = bus.reg_data;
        d_d     = '0;
        state_d = EMIT;
      end
      EMIT: begin
        wa_d = live_addr;
        wd_d = live_data;
        sh_d = sh_q << 4;
        d_d  = d_q + DW'(1);
        if (last_dig) begin
          state_d = (cur_q == last_q) ? FIN : NEXT;
        end
      end
      NEXT: begin
        cur_d   = at_top ? '0 : cur_q + REG_AW'(1);
        state_d = READ;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort cancels the strobe of the current cycle as well
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      wa_d    = wa_q;
      wd_d    = wd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      raddr_q <= '0;
      d_q     <= '0;
      sh_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      raddr_q <= raddr_d;
      d_q     <= d_d;
      sh_q    <= sh_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.reg_addr            = raddr_q;
  assign bus.ascii_write_en      = emit;
  assign bus.ascii_write_address = emit ? live_addr : wa_q;
  assign bus.ascii_input         = emit ? live_data : wd_q;
  assign bus.busy = (state_q == READ) || (state_q == LATCH) ||
                    (state_q == EMIT) || (state_q == NEXT);
  assign bus.done = (state_q == FIN) && !bus.abort;
endmodule

// File: tb/tb_reg_dump_engine.sv
// Directed bench for reg_dump_engine: a vector table of dump ranges
// plus hand sequences for abort, restart, reset and the 16-bit build.
module tb_reg_dump_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_dump_engine_if #(.WORD_SIZE(32), .NUM_REGS(32), .ADDR_W(13)) b32();
  reg_dump_engine_if #(.WORD_SIZE(16), .NUM_REGS(8), .ADDR_W(8)) b16();

  logic [31:0] regs32 [32];
  logic [15:0] regs16 [8];
  assign b32.reg_data = regs32[b32.reg_addr];
  assign b16.reg_data = regs16[b16.reg_addr];

  reg_dump_engine #(
    .WORD_SIZE(32), .NUM_REGS(32), .ROW_STRIDE(80),
    .COL_OFFSET(0), .ADDR_W(13)
  ) dut32 (.clk(clk), .rst(rst), .bus(b32));

  reg_dump_engine #(
    .WORD_SIZE(16), .NUM_REGS(8), .ROW_STRIDE(80),
    .COL_OFFSET(5), .ADDR_W(8)
  ) dut16 (.clk(clk), .rst(rst), .bus(b16));

  typedef struct {
    int f;
    int l;
    int nwr;
    int ncyc;
  } vec_t;

  vec_t        vt [5];
  int          errors = 0;
  int          checks = 0;
  int          done32_cnt = 0;
  int          done16_cnt = 0;
  int          wa [$];
  logic [31:0] wd [$];
  string       s_db;
  string       s16;

  always @(negedge clk) begin
    if (b32.done) done32_cnt++;
    if (b16.done) done16_cnt++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic dump32(input int f, input int l, input int poke,
                        input bit no_gap, output int ncyc,
                        output int nbusy);
    wa.delete();
    wd.delete();
    nbusy = 0;
    if (!no_gap) begin
      @(posedge clk);
      #1;
    end
    b32.first_reg = 5'(f);
    b32.last_reg  = 5'(l);
    b32.start     = 1'b1;
    @(posedge clk);
    #1;
    b32.start = 1'b0;
    ncyc = 1;
    while (!b32.done && ncyc < 1000) begin
      if (!b32.busy) nbusy++;
      if (b32.ascii_write_en) begin
        wa.push_back(int'(b32.ascii_write_address));
        wd.push_back(b32.ascii_input);
      end
      b32.start = (ncyc == poke);
      if (ncyc == poke) begin
        b32.first_reg = 5'd10;
        b32.last_reg  = 5'd20;
      end
      @(posedge clk);
      #1;
      ncyc++;
    end
    b32.start = 1'b0;
  endtask

  task automatic dump16(input int f, input int l, output int ncyc);
    wa.delete();
    wd.delete();
    @(posedge clk);
    #1;
    b16.first_reg = 3'(f);
    b16.last_reg  = 3'(l);
    b16.start     = 1'b1;
    @(posedge clk);
    #1;
    b16.start = 1'b0;
    ncyc = 1;
    while (!b16.done && ncyc < 200) begin
      if (b16.ascii_write_en) begin
        wa.push_back(int'(b16.ascii_write_address));
        wd.push_back(b16.ascii_input);
      end
      @(posedge clk);
      #1;
      ncyc++;
    end
  endtask

  task automatic model32(input int f, input int l, output int mism);
    int          r;
    int          idx;
    int          ea;
    logic [31:0] w;
    logic [3:0]  nb;
    logic [31:0] ed;
    r = f;
    idx = 0;
    mism = 0;
    for (int g = 0; g < 32; g++) begin
      for (int k = 0; k < 8; k++) begin
        w  = regs32[r];
        nb = w[31-4*k -: 4];
        ea = (r * 80 + k) % 8192;
        ed = {hexc(nb), 24'hFF_FFFF};
        if (idx >= wa.size() || wa[idx] != ea || wd[idx] !== ed)
          mism++;
        idx++;
      end
      if (r == l) break;
      r = (r + 1) % 32;
    end
    if (idx != wa.size()) mism++;
  endtask

  initial begin
    int nc;
    int nb;
    int mm;
    int cnt;
    int guard;
    int d0;

    vt[0] = '{f: 3,  l: 3,  nwr: 8,   ncyc: 11};
    vt[1] = '{f: 0,  l: 31, nwr: 256, ncyc: 352};
    vt[2] = '{f: 30, l: 1,  nwr: 32,  ncyc: 44};
    vt[3] = '{f: 5,  l: 7,  nwr: 24,  ncyc: 33};
    vt[4] = '{f: 31, l: 31, nwr: 8,   ncyc: 11};

    for (int i = 0; i < 32; i++)
      regs32[i] = 32'(i) * 32'h0813_5A27 + 32'h0123_4567;
    regs32[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) regs16[i] = 16'(i) * 16'h1111;
    regs16[4] = 16'h00A5;
    regs16[7] = 16'h1F3C;
    regs16[0] = 16'hB209;
    s_db = "DEADBEEF";
    s16  = "00A51F3CB209";

    rst = 1'b0;
    b32.start = 1'b0;
    b32.abort = 1'b0;
    b32.first_reg = '0;
    b32.last_reg = '0;
    b16.start = 1'b0;
    b16.abort = 1'b0;
    b16.first_reg = '0;
    b16.last_reg = '0;
    repeat (3) @(posedge clk);
    #1;

    chk("rst busy", 64'(b32.busy), 0);
    chk("rst done", 64'(b32.done), 0);
    chk("rst we", 64'(b32.ascii_write_en), 0);
    chk("rst addr", 64'(b32.ascii_write_address), 0);
    chk("rst data", 64'(b32.ascii_input), 0);
    chk("rst reg_addr", 64'(b32.reg_addr), 0);
    chk("rst16 we", 64'(b16.ascii_write_en), 0);

    // start on the very first edge with reset released
    rst = 1'b1;
    dump32(3, 3, 0, 1'b1, nc, nb);
    chk("first start cycles", 64'(nc), 11);
    chk("deadbeef writes", 64'(wa.size()), 8);
    mm = 0;
    for (int k = 0; k < 8; k++) begin
      if (k >= wa.size()) mm++;
      else if (wa[k] != 240 + k || wd[k][31:24] != s_db[k]) mm++;
    end
    chk("deadbeef text", 64'(mm), 0);

    for (int i = 0; i < 5; i++) begin
      dump32(vt[i].f, vt[i].l, 0, 1'b0, nc, nb);
      chk($sformatf("v%0d cycles", i), 64'(nc), 64'(vt[i].ncyc));
      chk($sformatf("v%0d writes", i), 64'(wa.size()), 64'(vt[i].nwr));
      chk($sformatf("v%0d busy", i), 64'(nb), 0);
      chk($sformatf("v%0d fin", i),
          64'({b32.done, b32.busy}), 64'(2'b10));
      model32(vt[i].f, vt[i].l, mm);
      chk($sformatf("v%0d content", i), 64'(mm), 0);
    end

    // abort during the third EMIT cycle
    @(posedge clk);
    #1;
    d0 = done32_cnt;
    b32.first_reg = 5'd3;
    b32.last_reg  = 5'd3;
    b32.start     = 1'b1;
    @(posedge clk);
    #1;
    b32.start = 1'b0;
    cnt = 0;
    guard = 0;
    while (guard < 20) begin
      if (b32.ascii_write_en) cnt++;
      if (cnt == 2) break;
      @(posedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1;
    b32.abort = 1'b1;
    #1;
    if (b32.ascii_write_en) cnt++;
    @(posedge clk);
    #1;
    b32.abort = 1'b0;
    chk("abort idle", 64'({b32.busy, b32.done, b32.ascii_write_en}), 0);
    repeat (12) begin
      @(posedge clk);
      #1;
      if (b32.ascii_write_en) cnt++;
    end
    chk("abort writes", 64'(cnt), 2);
    chk("abort no done", 64'(done32_cnt - d0), 0);
    dump32(3, 3, 0, 1'b0, nc, nb);
    chk("post abort cycles", 64'(nc), 11);
    model32(3, 3, mm);
    chk("post abort content", 64'(mm), 0);

    // start pulsed mid-dump must not restart or change the range
    dump32(3, 4, 5, 1'b0, nc, nb);
    chk("busy start cycles", 64'(nc), 22);
    chk("busy start writes", 64'(wa.size()), 16);
    model32(3, 4, mm);
    chk("busy start content", 64'(mm), 0);

    // reset in the middle of EMIT
    @(posedge clk);
    #1;
    b32.first_reg = 5'd3;
    b32.last_reg  = 5'd3;
    b32.start     = 1'b1;
    @(posedge clk);
    #1;
    b32.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mid emit we", 64'(b32.ascii_write_en), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mrst flags",
        64'({b32.busy, b32.done, b32.ascii_write_en}), 0);
    chk("mrst addr", 64'(b32.ascii_write_address), 0);
    chk("mrst data", 64'(b32.ascii_input), 0);
    chk("mrst reg_addr", 64'(b32.reg_addr), 0);

    // 16-bit build, column offset 5, 8-bit buffer address
    dump16(4, 4, nc);
    chk("w16 cycles", 64'(nc), 7);
    chk("w16 writes", 64'(wa.size()), 4);
    mm = 0;
    for (int k = 0; k < 4; k++) begin
      if (k >= wa.size()) mm++;
      else if (wa[k] != 69 + k || wd[k] !== {s16[k], 24'hFF_FFFF}) mm++;
    end
    chk("w16 text", 64'(mm), 0);

    dump16(7, 0, nc);
    chk("w16 wrap cycles", 64'(nc), 14);
    chk("w16 wrap writes", 64'(wa.size()), 8);
    mm = 0;
    for (int k = 0; k < 8; k++) begin
      if (k >= wa.size()) mm++;
      else if (wd[k][31:24] != s16[4 + k]) mm++;
      else if (k < 4 && wa[k] != 53 + k) mm++;
      else if (k >= 4 && wa[k] != 5 + k - 4) mm++;
    end
    chk("w16 wrap text", 64'(mm), 0);
    @(posedge clk);
    #1;
    chk("w16 done count", 64'(done16_cnt), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
